ram_loader: RTL and testbench
=============================

Name: ram_loader

Overview:
- Write-side counterpart to the synchronous-read `ram` block.
- Accepts a byte stream over a valid/ready handshake and writes it to consecutive RAM addresses from a programmable base.
- Then reads the same region back and checks a running checksum, so the loaded image is confirmed before the core is released from boot.
- Sits between the boot/UART byte source and the `ram` write port.

Parameters:
- ADDRESS_BITS, 6, RAM address width; must equal the attached `ram` ADDRESS_BITS.
- DATA_BITS, 8, word width of the stream and the RAM.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  one-cycle request to begin a load; sampled only in IDLE.
- base_addr  input  ADDRESS_BITS  first RAM address; captured on accepted start.
- length  input  ADDRESS_BITS+1  number of words, 0..2^ADDRESS_BITS; captured on accepted start.
- in_valid  input  1  stream word present.
- in_data  input  DATA_BITS  stream word.
- in_ready  output  1  loader accepts in_data this cycle.
- mem_enable  output  1  RAM write strobe (registered).
- mem_address  output  ADDRESS_BITS  RAM address (registered).
- mem_data_in  output  DATA_BITS  RAM write data (registered).
- mem_data_out  input  DATA_BITS  RAM read data, valid one cycle after the address is sampled.
- busy  output  1  high in any state except IDLE.
- done  output  1  one-cycle pulse at completion.
- error  output  1  verify mismatch flag; valid with done, held until next accepted start.
- checksum  output  DATA_BITS  write-side sum mod 2^DATA_BITS; held until next accepted start.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - All outputs go to 0: in_ready, mem_enable, mem_address, mem_data_in, busy, done, error, checksum.
  - Internal counters and sums are cleared.
  - Reset mid-load aborts immediately: no further writes, no done pulse. Words already written stay in RAM.
- States: IDLE, WRITE, VERIFY, DONE.
- IDLE:
  - On start=1, capture base_addr and length, clear both sums and error, and set index to 0.
  - If length=0, go to DONE.
  - Otherwise go to WRITE.
  - start in any other state is ignored.
- WRITE:
  - in_ready = (state==WRITE) && (index<length). It is combinational from registered state.
  - A word is accepted when in_valid && in_ready.
  - On an accepted word:
    - The next cycle drives mem_enable=1, mem_address=(base+index) mod 2^ADDRESS_BITS, mem_data_in=word.
    - wsum += word, mod 2^DATA_BITS.
    - index increments.
  - mem_enable is 0 in every cycle not following an accept. Source stalls (in_valid=0) are tolerated indefinitely.
  - When the last word is accepted, go to VERIFY. The final write strobe is issued in the first VERIFY cycle.
- VERIFY:
  - Issue read addresses (base+j) mod 2^ADDRESS_BITS for j=0..length-1, one per cycle, with mem_enable=0.
  - The first read address is driven the cycle after the final write. Read-during-write is therefore never needed.
  - mem_data_out is sampled at the end of the second cycle after its address register is driven, a 2-cycle pipeline. Each sampled word is added to rsum.
  - After the last sample, go to DONE.
- DONE (one cycle):
  - done=1.
  - error=(rsum != wsum).
  - checksum=wsum.
  - Go to IDLE next cycle. busy drops to 0 in that IDLE cycle.
- Wrap-around: address arithmetic wraps modulo 2^ADDRESS_BITS. length=2^ADDRESS_BITS writes every location exactly once.
- Timing at full stream rate: start accepted at edge 0; done asserted (2·length + 3) cycles later. length=0 gives done one cycle after start.

Test Plan:
- Basic load:
  - base=0x10, length=4, stream 0x11,0x22,0x33,0x44 with in_valid held high.
  - Writes at 0x10..0x13 on consecutive cycles.
  - done pulses once with error=0, checksum=0xAA.
- Wrap:
  - base=0x3E, length=4, stream 0x01..0x04.
  - Writes land at 0x3E,0x3F,0x00,0x01.
  - checksum=0x0A, error=0.
- Stalls:
  - length=3 with in_valid gapped (1,0,0,1,0,1).
  - Exactly 3 mem_enable pulses, each the cycle after an accept.
  - in_ready=0 after the third accept.
  - done/error=0 as in the basic load.
- Corruption:
  - Bench RAM model flips bit 0 of address 0x11 before read-back in the basic load.
  - done=1 with error=1.
  - checksum=0xAA.
- Zero length and ignored start:
  - length=0 gives done one cycle after start with no mem_enable and error=0.
  - start pulsed during WRITE does not change base or length.
- Reset mid-operation:
  - rst_n=0 after 2 of 4 words are accepted.
  - Next cycle: all outputs 0, state IDLE, no done.
  - A fresh load afterwards completes normally.

Source files
------------

// File: rtl/ram_loader.sv
// ram_loader
//   Boot-time image loader for the synchronous-read `ram` block. It takes a
//   byte stream over valid/ready and writes it to consecutive addresses from
//   a programmable base. It then reads the same region back and compares a
//   read-side sum against the write-side sum, so a bad image is flagged
//   before the core leaves boot.
//
// Ports
//   clk, rst_n      rising-edge clock, synchronous active-low reset
//   start           load request, honoured only in IDLE
//   base_addr       first RAM address, captured on accepted start
//   length          word count 0..2^ADDRESS_BITS, captured on accepted start
//   in_valid/in_data/in_ready   byte-stream handshake
//   mem_enable, mem_address, mem_data_in   registered RAM write/read port
//   mem_data_out    RAM read data, one cycle after the address is sampled
//   busy            high outside IDLE
//   done            one-cycle completion pulse
//   error           read-back sum differs from write sum (valid with done)
//   checksum        write-side sum modulo 2^DATA_BITS
//
// state  | meaning
// IDLE   | waiting for start
// WRITE  | accepting stream words, one RAM write per accepted word
// VERIFY | issuing read-back addresses and summing returned words
// DONE   | one cycle; done pulses, error/checksum updated

module ram_loader #(
  parameter int ADDRESS_BITS = 6,
  parameter int DATA_BITS    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDRESS_BITS-1:0] base_addr,
  input  logic [ADDRESS_BITS:0]   length,
  input  logic                    in_valid,
  input  logic [DATA_BITS-1:0]    in_data,
  output logic                    in_ready,
  output logic                    mem_enable,
  output logic [ADDRESS_BITS-1:0] mem_address,
  output logic [DATA_BITS-1:0]    mem_data_in,
  input  logic [DATA_BITS-1:0]    mem_data_out,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [DATA_BITS-1:0]    checksum
);

  localparam int CW = ADDRESS_BITS + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WRITE  = 2'd1;
  localparam logic [1:0] S_VERIFY = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]              state;
  logic [ADDRESS_BITS-1:0] base;
  logic [CW-1:0]           len;
  logic [CW-1:0]           idx;      // words accepted so far
  logic [CW-1:0]           rd_idx;   // read addresses issued so far
  logic [CW-1:0]           smp_idx;  // read words summed so far
  logic [DATA_BITS-1:0]    wsum;
  logic [DATA_BITS-1:0]    rsum;
  logic [DATA_BITS-1:0]    cap;
  logic                    p0, p1, p2;
  logic                    accept;
  logic [DATA_BITS-1:0]    rsum_next;

  assign in_ready  = (state == S_WRITE) && (idx < len);
  assign accept    = in_valid && in_ready;
  assign busy      = (state != S_IDLE);
  assign rsum_next = rsum + cap;

  // Read-back pipeline: p0 marks a read address on mem_address, p1 the cycle
  // the RAM samples it, p2 the cycle its word sits in cap. The word is
  // summed one edge later, three edges after the address was registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      base        <= '0;
      len         <= '0;
      idx         <= '0;
      rd_idx      <= '0;
      smp_idx     <= '0;
      wsum        <= '0;
      rsum        <= '0;
      cap         <= '0;
      p0          <= 1'b0;
      p1          <= 1'b0;
      p2          <= 1'b0;
      mem_enable  <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
      done        <= 1'b0;
      error       <= 1'b0;
      checksum    <= '0;
    end else begin
      mem_enable <= 1'b0;
      done       <= 1'b0;
      p0         <= 1'b0;
      p1         <= p0;
      p2         <= p1;
      cap        <= mem_data_out;

      case (state)
        S_IDLE: begin
          if (start) begin
            base     <= base_addr;
            len      <= length;
            idx      <= '0;
            rd_idx   <= '0;
            smp_idx  <= '0;
            wsum     <= '0;
            rsum     <= '0;
            error    <= 1'b0;
            checksum <= '0;
            if (length == '0) begin
              // Empty image: sums are both zero, so complete immediately.
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_WRITE;
            end
          end
        end

        S_WRITE: begin
          if (accept) begin
            mem_enable  <= 1'b1;
            mem_address <= base + idx[ADDRESS_BITS-1:0];
            mem_data_in <= in_data;
            wsum        <= wsum + in_data;
            idx         <= idx + CW'(1);
            if (idx + CW'(1) == len) state <= S_VERIFY;
          end
        end

        S_VERIFY: begin
          // The first VERIFY cycle carries the final write strobe, so the
          // first read address lands on the following cycle.
          if (rd_idx < len) begin
            mem_address <= base + rd_idx[ADDRESS_BITS-1:0];
            rd_idx      <= rd_idx + CW'(1);
            p0          <= 1'b1;
          end
          if (p2) begin
            rsum    <= rsum_next;
            smp_idx <= smp_idx + CW'(1);
            if (smp_idx + CW'(1) == len) begin
              state    <= S_DONE;
              done     <= 1'b1;
              error    <= (rsum_next != wsum);
              checksum <= wsum;
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
module tb_ram_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [5:0] base_addr = '0;
  logic [6:0] length = '0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic       mem_enable;
  logic [5:0] mem_address;
  logic [7:0] mem_data_in;
  logic [7:0] mem_data_out = '0;
  logic       busy;
  logic       done;
  logic       error;
  logic [7:0] checksum;

  logic [7:0] ram [0:63];
  bit         corrupt_en = 1'b0;
  logic [5:0] corrupt_addr = '0;
  logic [7:0] stream_q [$];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ram_loader #(.ADDRESS_BITS(6), .DATA_BITS(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .base_addr    (base_addr),
    .length       (length),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .mem_enable   (mem_enable),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .checksum     (checksum)
  );

  // Synchronous-read RAM; optionally corrupts bit 0 of one location on write.
  always @(posedge clk) begin
    if (mem_enable)
      ram[mem_address] <= (corrupt_en && mem_address == corrupt_addr) ?
                          (mem_data_in ^ 8'h01) : mem_data_in;
    mem_data_out <= ram[mem_address];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill_random(input int len);
    stream_q = {};
    for (int i = 0; i < len; i++) stream_q.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"},    in_ready,    0);
    chk({tag, "_mem_enable"},  mem_enable,  0);
    chk({tag, "_mem_address"}, mem_address, 0);
    chk({tag, "_mem_data_in"}, mem_data_in, 0);
    chk({tag, "_busy"},        busy,        0);
    chk({tag, "_done"},        done,        0);
    chk({tag, "_error"},       error,       0);
    chk({tag, "_checksum"},    checksum,    0);
  endtask

  // mode: 0 = in_valid always high, 1 = random gaps, 2 = pattern 1,0,0,1,0,1
  task automatic run_load(input int b, input int len, input int mode,
                          input bit corrupt, input int corrupt_off, input bit poke);
    int  exp_sum, k, n_wr, cyc, last_acc, exp_done_cyc;
    bit  acc, got_done;
    bit  pat [6] = '{1, 0, 0, 1, 0, 1};

    exp_sum = 0;
    for (int i = 0; i < len; i++) exp_sum += int'(stream_q[i]);
    exp_sum = exp_sum % 256;
    corrupt_en   = corrupt;
    corrupt_addr = 6'((b + corrupt_off) % 64);

    base_addr = 6'(b);
    length    = 7'(len);
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);

    if (len == 0) begin
      chk("zero_done", done, 1);
      chk("zero_error", error, 0);
      chk("zero_checksum", checksum, 0);
      chk("zero_no_write", mem_enable, 0);
      @(posedge clk); #1;
      chk("zero_done_drop", done, 0);
      chk("zero_busy_drop", busy, 0);
      chk("zero_no_write2", mem_enable, 0);
      return;
    end

    k = 0; n_wr = 0; cyc = 0; last_acc = -1; got_done = 0;
    while (!got_done && cyc < 6 * len + 400) begin
      if (k < len) begin
        case (mode)
          0:       in_valid = 1'b1;
          1:       in_valid = ($urandom_range(0, 2) != 0);
          default: in_valid = pat[cyc % 6];
        endcase
        in_data = stream_q[k];
      end else begin
        in_valid = 1'b0;
        in_data  = 8'($urandom_range(0, 255));
      end
      if (poke && cyc == 1) begin
        start     = 1'b1;
        base_addr = 6'(b) ^ 6'h15;
        length    = 7'(len % 3);
      end else begin
        start     = 1'b0;
        base_addr = 6'(b);
        length    = 7'(len);
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        k++;
        last_acc = cyc;
      end
      chk("wr_strobe", mem_enable, acc);
      if (mem_enable) begin
        if (n_wr < len) begin
          chk("wr_addr", mem_address, (b + n_wr) % 64);
          chk("wr_data", mem_data_in, stream_q[n_wr]);
        end else begin
          chk("extra_write", 1, 0);
        end
        n_wr++;
      end
      if (acc && k == len) chk("ready_after_last", in_ready, 0);
      if (done) begin
        got_done = 1;
        exp_done_cyc = (mode == 0) ? 2 * len + 3 : last_acc + len + 3;
        chk("done_cycle", cyc, exp_done_cyc);
        chk("error", error, corrupt);
        chk("checksum", checksum, exp_sum);
        chk("write_count", n_wr, len);
      end
    end
    start    = 1'b0;
    in_valid = 1'b0;
    if (!got_done) chk("done_timeout", 0, 1);
    @(posedge clk); #1;
    chk("done_pulse", done, 0);
    chk("busy_idle", busy, 0);
    chk("checksum_held", checksum, exp_sum);
    chk("error_held", error, corrupt);
  endtask

  task automatic reset_mid();
    int k;
    fill_random(4);
    base_addr = 6'($urandom_range(0, 63));
    length    = 7'd4;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (k < 2) begin
      in_valid = 1'b1;
      in_data  = stream_q[k];
      if (in_ready) k++;
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_all_zero("mid_reset");
    rst_n    = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("post_reset_no_done", done, 0);
      chk("post_reset_no_write", mem_enable, 0);
    end
  endtask

  initial begin
    int len, b, mode;
    for (int i = 0; i < 64; i++) ram[i] = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    stream_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_load(16, 4, 0, 0, 0, 0);
    stream_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_load(62, 4, 0, 0, 0, 0);
    fill_random(3);
    run_load(5, 3, 2, 0, 0, 0);
    stream_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_load(16, 4, 0, 1, 1, 0);
    run_load(7, 0, 0, 0, 0, 0);
    fill_random(4);
    run_load(20, 4, 0, 0, 0, 1);
    fill_random(64);
    run_load(9, 64, 1, 0, 0, 0);

    reset_mid();
    fill_random(4);
    run_load(33, 4, 0, 0, 0, 0);

    for (int t = 0; t < 20; t++) begin
      len  = $urandom_range(1, 64);
      b    = $urandom_range(0, 63);
      mode = $urandom_range(0, 1);
      fill_random(len);
      run_load(b, len, mode, ($urandom_range(0, 3) == 0),
               $urandom_range(0, len - 1), ($urandom_range(0, 1) == 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
